// File: rtl/test_run_controller_pkg.sv
// Shared types and verdict codes for the test run controller.
package test_run_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEQ  = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [1:0] FAIL_NONE    = 2'd0;
   localparam logic [1:0] FAIL_CHAN    = 2'd1;
   localparam logic [1:0] FAIL_TIMEOUT = 2'd2;
   localparam logic [1:0] FAIL_ABORT   = 2'd3;

endpackage

// File: rtl/test_run_controller_if.sv
// Control/status bundle between a test driver (master) and the run controller (slave).
interface test_run_controller_if #(
   parameter int NUM_RESETS = 3,
   parameter int DELAY_W    = 16,
   parameter int NUM_CH     = 4,
   parameter int CYC_W      = 64
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic                          start;
   logic                          abort;
   logic [NUM_RESETS*DELAY_W-1:0] rst_delay;
   logic [CYC_W-1:0]              max_cycles;
   logic [NUM_CH-1:0]             ch_enable;
   logic [NUM_CH-1:0]             ch_success;
   logic [NUM_CH-1:0]             ch_fail;
   logic [NUM_RESETS-1:0]         resets_out;
   logic                          running;
   logic                          done;
   logic                          pass;
   logic [1:0]                    fail_code;
   logic [CH_W-1:0]               fail_ch;
   logic [CYC_W-1:0]              cycle_count;

   modport master (
      output start, abort, rst_delay, max_cycles, ch_enable, ch_success, ch_fail,
      input  resets_out, running, done, pass, fail_code, fail_ch, cycle_count
   );

   modport slave (
      input  start, abort, rst_delay, max_cycles, ch_enable, ch_success, ch_fail,
      output resets_out, running, done, pass, fail_code, fail_ch, cycle_count
   );
endinterface

// File: rtl/test_run_controller_reset_stage.sv
// One sequenced reset output: captures its release delay on start and
// drops its reset (sticky) once the shared sequence counter reaches it.
module reset_stage #(
   parameter int DELAY_W = 16
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               i_capture,
   input  logic               i_seq_en,
   input  logic               i_force,
   input  logic [DELAY_W-1:0] i_delay,
   input  logic [DELAY_W-1:0] i_seq_cnt,
   output logic               o_rst,
   output logic               o_clear
);
   logic [DELAY_W-1:0] r_delay;
   logic               r_rst;

   // Delay capture on start; reset is re-asserted on start/abort, released in sequence.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_delay <= '0;
         r_rst   <= 1'b1;
      end else if (i_capture) begin
         r_delay <= i_delay;
         r_rst   <= 1'b1;
      end else if (i_force) begin
         r_rst   <= 1'b1;
      end else if (i_seq_en && (i_seq_cnt >= r_delay)) begin
         r_rst   <= 1'b0;
      end else begin
         r_rst   <= r_rst;
      end
   end

   // Already released, or releasing on this edge: lets the FSM leave SEQ in step.
   assign o_clear = !r_rst || (i_seq_cnt >= r_delay);
   assign o_rst   = r_rst;

endmodule

// File: rtl/test_run_controller.sv
// Run controller: sequenced reset release, run-cycle counting with timeout,
// per-channel success/fail collection and a registered verdict.
module test_run_controller
   import test_run_ctrl_pkg::*;
#(
   parameter int NUM_RESETS   = 3,
   parameter int DELAY_W      = 16,
   parameter int NUM_CH       = 4,
   parameter int CYC_W        = 64,
   parameter int SUCCESS_MODE = 0
) (
   input logic                  clock,
   input logic                  reset_n,
   test_run_controller_if.slave bus
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   state_t                r_state, w_next_state;
   logic [DELAY_W-1:0]    r_seq_cnt;
   logic [CYC_W-1:0]      r_max_cycles, r_cycle_count;
   logic [NUM_CH-1:0]     r_ch_enable, r_sticky;
   logic                  r_running, r_done, r_pass;
   logic [1:0]            r_fail_code;
   logic [CH_W-1:0]       r_fail_ch;
   logic [NUM_RESETS-1:0] w_rst, w_clear;
   logic                  w_capture, w_seq_en, w_force, w_to_done, w_next_pass;
   logic [1:0]            w_next_code;
   logic [CH_W-1:0]       w_next_ch, w_low_idx;
   logic [NUM_CH-1:0]     w_fail_m, w_succ_m;
   logic                  w_success, w_timeout;

   genvar g;
   generate
      for (g = 0; g < NUM_RESETS; g++) begin : g_stage
         reset_stage #(.DELAY_W(DELAY_W)) u_stage (
            .clock     (clock),
            .reset_n   (reset_n),
            .i_capture (w_capture),
            .i_seq_en  (w_seq_en),
            .i_force   (w_force),
            .i_delay   (bus.rst_delay[g*DELAY_W +: DELAY_W]),
            .i_seq_cnt (r_seq_cnt),
            .o_rst     (w_rst[g]),
            .o_clear   (w_clear[g])
         );
      end
   endgenerate

   assign w_fail_m  = bus.ch_fail & r_ch_enable;
   // Success mask includes this edge's reports, not only the sticky history.
   assign w_succ_m  = (r_sticky | bus.ch_success) & r_ch_enable;
   assign w_success = (r_ch_enable != '0) &&
                      ((SUCCESS_MODE == 0) ? (w_succ_m == r_ch_enable) : (w_succ_m != '0));
   assign w_timeout = (r_max_cycles != '0) && (r_cycle_count == r_max_cycles);

   // Lowest-index failing channel (scan from the top so the lowest wins).
   always_comb begin
      w_low_idx = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         w_low_idx = w_fail_m[i] ? CH_W'(i) : w_low_idx;
      end
   end

   // Next state, control strobes and verdict; priority abort > fail > timeout > success.
   always_comb begin
      w_next_state = r_state;
      w_capture    = 1'b0;
      w_seq_en     = 1'b0;
      w_force      = 1'b0;
      w_to_done    = 1'b0;
      w_next_pass  = 1'b0;
      w_next_code  = FAIL_NONE;
      w_next_ch    = '0;
      case (r_state)
         IDLE, DONE: begin
            if (bus.start) begin
               w_capture    = 1'b1;
               w_next_state = SEQ;
            end else begin
               w_next_state = r_state;
            end
         end
         SEQ: begin
            if (bus.abort) begin
               w_force      = 1'b1;
               w_to_done    = 1'b1;
               w_next_code  = FAIL_ABORT;
               w_next_state = DONE;
            end else begin
               w_seq_en     = 1'b1;
               w_next_state = (&w_clear) ? RUN : SEQ;
            end
         end
         RUN: begin
            if (bus.abort) begin
               w_force      = 1'b1;
               w_to_done    = 1'b1;
               w_next_code  = FAIL_ABORT;
               w_next_state = DONE;
            end else if (w_fail_m != '0) begin
               w_to_done    = 1'b1;
               w_next_code  = FAIL_CHAN;
               w_next_ch    = w_low_idx;
               w_next_state = DONE;
            end else if (w_timeout) begin
               w_to_done    = 1'b1;
               w_next_code  = FAIL_TIMEOUT;
               w_next_state = DONE;
            end else if (w_success) begin
               w_to_done    = 1'b1;
               w_next_pass  = 1'b1;
               w_next_state = DONE;
            end else begin
               w_next_state = RUN;
            end
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_next_state;
   end

   // Saturating sequence counter, restarted on every accepted start.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)                              r_seq_cnt <= '0;
      else if (w_capture)                        r_seq_cnt <= '0;
      else if (w_seq_en && (r_seq_cnt != '1))    r_seq_cnt <= r_seq_cnt + DELAY_W'(1);
      else                                       r_seq_cnt <= r_seq_cnt;
   end

   // Run configuration, sampled only when a start is accepted.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_max_cycles <= '0;
         r_ch_enable  <= '0;
      end else if (w_capture) begin
         r_max_cycles <= bus.max_cycles;
         r_ch_enable  <= bus.ch_enable;
      end else begin
         r_max_cycles <= r_max_cycles;
         r_ch_enable  <= r_ch_enable;
      end
   end

   // Saturating run-cycle counter and sticky success mask, both active only in RUN.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_cycle_count <= '0;
         r_sticky      <= '0;
      end else if (w_capture) begin
         r_cycle_count <= '0;
         r_sticky      <= '0;
      end else if (r_state == RUN) begin
         r_cycle_count <= (r_cycle_count == '1) ? r_cycle_count : r_cycle_count + CYC_W'(1);
         r_sticky      <= r_sticky | (bus.ch_success & r_ch_enable);
      end else begin
         r_cycle_count <= r_cycle_count;
         r_sticky      <= r_sticky;
      end
   end

   // Registered status and verdict; verdict cleared on start, latched on entry to DONE.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_running   <= 1'b0;
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
         r_fail_code <= FAIL_NONE;
         r_fail_ch   <= '0;
      end else begin
         r_running <= (w_next_state == RUN);
         r_done    <= (w_next_state == DONE);
         if (w_capture) begin
            r_pass      <= 1'b0;
            r_fail_code <= FAIL_NONE;
            r_fail_ch   <= '0;
         end else if (w_to_done) begin
            r_pass      <= w_next_pass;
            r_fail_code <= w_next_code;
            r_fail_ch   <= w_next_ch;
         end else begin
            r_pass      <= r_pass;
            r_fail_code <= r_fail_code;
            r_fail_ch   <= r_fail_ch;
         end
      end
   end

   assign bus.resets_out  = w_rst;
   assign bus.running     = r_running;
   assign bus.done        = r_done;
   assign bus.pass        = r_pass;
   assign bus.fail_code   = r_fail_code;
   assign bus.fail_ch     = r_fail_ch;
   assign bus.cycle_count = r_cycle_count;

endmodule

// File: tb/tb_test_run_controller.sv
// Scoreboard bench for test_run_controller: a driver issues runs and pushes the
// reference-model outcome; a monitor pops and compares each time done rises.
module tb_test_run_controller;
   localparam int NR   = 3;
   localparam int DW   = 16;
   localparam int NC   = 4;
   localparam int CW   = 64;
   localparam int MODE = 0;
   localparam int CHW  = 2;
   localparam logic [15:0] NEVER = 16'hFFFF;

   typedef struct packed {
      logic                 pass;
      logic [1:0]           code;
      logic [CHW-1:0]       ch;
      logic [CW-1:0]        cnt;
      logic [NR-1:0]        rst;
      logic [15:0]          run_rel;
      logic [NR-1:0][15:0]  fall_rel;
      logic [15:0]          end_rel;
   } exp_t;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   test_run_controller_if #(.NUM_RESETS(NR), .DELAY_W(DW), .NUM_CH(NC), .CYC_W(CW)) bus ();

   test_run_controller #(
      .NUM_RESETS(NR), .DELAY_W(DW), .NUM_CH(NC), .CYC_W(CW), .SUCCESS_MODE(MODE)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int n_cmp = 0;
   int n_err = 0;
   int edge_n = 0;
   int runs_pushed = 0;
   int runs_checked = 0;
   exp_t q[$];

   int            cfg_d [NR];
   logic [CW-1:0] cfg_max;
   logic [NC-1:0] cfg_en;
   int            cfg_abort;
   int            cur_L;
   logic [NC-1:0] succ_tab [64];
   logic [NC-1:0] fail_tab [64];

   always @(posedge clock) edge_n <= edge_n + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_cfg();
      for (int k = 0; k < 64; k++) begin
         succ_tab[k] = '0;
         fail_tab[k] = '0;
      end
      cfg_abort = 0;
   endtask

   // Reference model: plays the run out edge by edge (edge 0 = start edge).
   task automatic model(output exp_t e);
      int  mx;
      bit  fin;
      logic [NC-1:0] sticky, fm;
      mx = 0;
      for (int i = 0; i < NR; i++) if (cfg_d[i] > mx) mx = cfg_d[i];
      cur_L = mx + 1;
      e = '0;
      if (cfg_abort != 0 && cfg_abort <= cur_L) begin
         e.code    = 2'd3;
         e.rst     = '1;
         e.run_rel = NEVER;
         e.end_rel = 16'(cfg_abort);
         for (int i = 0; i < NR; i++)
            e.fall_rel[i] = (cfg_d[i] + 1 < cfg_abort) ? 16'(cfg_d[i] + 1) : NEVER;
      end else begin
         e.run_rel = 16'(cur_L);
         for (int i = 0; i < NR; i++) e.fall_rel[i] = 16'(cfg_d[i] + 1);
         sticky = '0;
         fin = 1'b0;
         for (int k = 0; k < 64 && !fin; k++) begin
            sticky = sticky | (succ_tab[k] & cfg_en);
            fm = fail_tab[k] & cfg_en;
            fin = 1'b1;
            if (cur_L + 1 + k == cfg_abort) begin
               e.code = 2'd3;
               e.rst  = '1;
            end else if (fm != '0) begin
               e.code = 2'd1;
               for (int c = NC - 1; c >= 0; c--) if (fm[c]) e.ch = CHW'(c);
            end else if (cfg_max != '0 && CW'(k) == cfg_max) begin
               e.code = 2'd2;
            end else if (cfg_en != '0 && ((MODE == 0) ? (sticky == cfg_en) : (sticky != '0))) begin
               e.pass = 1'b1;
            end else begin
               fin = 1'b0;
            end
            if (fin) begin
               e.cnt     = CW'(k + 1);
               e.end_rel = 16'(cur_L + 1 + k);
            end
         end
      end
   endtask

   task automatic run_one();
      exp_t e;
      int   k;
      model(e);
      q.push_back(e);
      runs_pushed++;
      @(posedge clock); #1;
      bus.start = 1'b1;
      for (int i = 0; i < NR; i++) bus.rst_delay[i*DW +: DW] = DW'(cfg_d[i]);
      bus.max_cycles = cfg_max;
      bus.ch_enable  = cfg_en;
      @(posedge clock); #1;
      bus.start = 1'b0;
      chk("start_cycle_count", bus.cycle_count, 64'd0);
      chk("start_verdict", {61'd0, bus.pass, bus.fail_code}, 64'd0);
      chk("start_resets", 64'(bus.resets_out), 64'(3'b111));
      // Config inputs must have been sampled already; scramble them.
      bus.rst_delay  = (NR*DW)'({$urandom(), $urandom()});
      bus.max_cycles = {$urandom(), $urandom()};
      bus.ch_enable  = NC'($urandom());
      for (int rel = 1; rel <= int'(e.end_rel); rel++) begin
         k = rel - cur_L - 1;
         bus.abort = (rel == cfg_abort);
         if (k >= 0) begin
            bus.ch_success = succ_tab[k];
            bus.ch_fail    = fail_tab[k];
         end else begin
            bus.ch_success = NC'($urandom());
            bus.ch_fail    = NC'($urandom());
         end
         @(posedge clock); #1;
      end
      bus.abort      = 1'b0;
      bus.ch_success = '0;
      bus.ch_fail    = '0;
      for (int w = 0; w < 6; w++) begin
         if (runs_checked == runs_pushed) break;
         @(posedge clock);
      end
      #1;
      chk("done_seen", 64'(runs_checked), 64'(runs_pushed));
      if (runs_checked != runs_pushed) begin
         q.delete();
         runs_checked = runs_pushed;
      end
   endtask

   // Monitor: records release/run edges relative to the start edge, checks on done.
   initial begin
      exp_t o, e;
      int   ostart;
      logic prev_done;
      logic [NR-1:0] prev_rst;
      ostart    = 0;
      o         = '0;
      prev_done = 1'b0;
      prev_rst  = '1;
      forever begin
         @(negedge clock);
         if (bus.start && reset_n) begin
            ostart    = edge_n + 1;
            o.fall_rel = '1;
            o.run_rel  = NEVER;
         end else begin
            for (int i = 0; i < NR; i++)
               if (prev_rst[i] && !bus.resets_out[i] && o.fall_rel[i] == NEVER)
                  o.fall_rel[i] = 16'(edge_n - ostart);
            if (bus.running && o.run_rel == NEVER) o.run_rel = 16'(edge_n - ostart);
            if (bus.done && !prev_done) begin
               if (q.size() == 0) begin
                  chk("unexpected_done", 64'd1, 64'd0);
               end else begin
                  e = q.pop_front();
                  chk("pass", 64'(bus.pass), 64'(e.pass));
                  chk("fail_code", 64'(bus.fail_code), 64'(e.code));
                  chk("fail_ch", 64'(bus.fail_ch), 64'(e.ch));
                  chk("cycle_count", bus.cycle_count, e.cnt);
                  chk("resets_at_done", 64'(bus.resets_out), 64'(e.rst));
                  chk("running_edge", 64'(o.run_rel), 64'(e.run_rel));
                  for (int i = 0; i < NR; i++)
                     chk("release_edge", 64'(o.fall_rel[i]), 64'(e.fall_rel[i]));
                  chk("done_edge", 64'(edge_n - ostart), 64'(e.end_rel));
                  runs_checked++;
               end
            end
         end
         prev_done = bus.done;
         prev_rst  = bus.resets_out;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got time limit expected completion");
      $fatal(1);
   end

   initial begin
      int L;
      bus.start = 1'b0; bus.abort = 1'b0; bus.rst_delay = '0; bus.max_cycles = '0;
      bus.ch_enable = '0; bus.ch_success = '0; bus.ch_fail = '0;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_resets", 64'(bus.resets_out), 64'(3'b111));
      chk("rst_status", {60'd0, bus.running, bus.done, bus.pass, bus.fail_ch == '0}, 64'd1);
      chk("rst_code", 64'(bus.fail_code), 64'd0);
      chk("rst_count", bus.cycle_count, 64'd0);
      #2 reset_n = 1'b1;

      // 1: release order {0,5,2}, timeout ending
      clear_cfg(); cfg_d = '{0, 5, 2}; cfg_en = 4'b0001; cfg_max = 64'd3; run_one();
      // 2: mode 0, two enabled channels report at different cycles
      clear_cfg(); cfg_d = '{0, 0, 0}; cfg_en = 4'b0101; cfg_max = 64'd0;
      succ_tab[3] = 4'b0001; succ_tab[7] = 4'b0100; run_one();
      // 3: timeout with no success
      clear_cfg(); cfg_d = '{1, 2, 3}; cfg_en = 4'b1111; cfg_max = 64'd10; run_one();
      // 4: fail, success and timeout on the same edge
      clear_cfg(); cfg_d = '{2, 0, 1}; cfg_en = 4'b1111; cfg_max = 64'd10;
      succ_tab[10] = 4'b1111; fail_tab[10] = 4'b1100; run_one();
      // 5: abort in SEQ, then a fresh run
      clear_cfg(); cfg_d = '{100, 100, 100}; cfg_en = 4'b0011; cfg_max = 64'd5; cfg_abort = 20; run_one();
      clear_cfg(); cfg_d = '{3, 1, 0}; cfg_en = 4'b0010; cfg_max = 64'd0; succ_tab[4] = 4'b0010; run_one();

      // 6: asynchronous reset mid-RUN, start ignored while reset is held
      @(posedge clock); #1;
      bus.start = 1'b1; bus.rst_delay = '0; bus.max_cycles = '0; bus.ch_enable = '0;
      @(posedge clock); #1;
      bus.start = 1'b0;
      repeat (6) @(posedge clock);
      #1;
      chk("t6_running", 64'(bus.running), 64'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("t6_async_resets", 64'(bus.resets_out), 64'(3'b111));
      chk("t6_async_status", {61'd0, bus.running, bus.done, bus.pass}, 64'd0);
      chk("t6_async_count", bus.cycle_count, 64'd0);
      bus.start = 1'b1;
      @(posedge clock); #1;
      chk("t6_start_in_reset", {60'd0, bus.running, bus.done, bus.resets_out == 3'b111, bus.fail_code == 2'd0}, 64'd3);
      bus.start = 1'b0;
      #2 reset_n = 1'b1;
      @(posedge clock); #1;
      chk("t6_after_release", {62'd0, bus.running, bus.done}, 64'd0);

      // Randomized runs
      for (int r = 0; r < 25; r++) begin
         clear_cfg();
         L = 0;
         for (int i = 0; i < NR; i++) begin
            cfg_d[i] = $urandom_range(0, 12);
            if (cfg_d[i] > L) L = cfg_d[i];
         end
         L = L + 1;
         cfg_en  = NC'($urandom_range(0, 15));
         cfg_max = CW'($urandom_range(0, 30));
         cfg_abort = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, L + 30)) : 0;
         for (int k = 0; k < 64; k++)
            for (int c = 0; c < NC; c++) begin
               succ_tab[k][c] = ($urandom_range(0, 5) == 0);
               fail_tab[k][c] = ($urandom_range(0, 59) == 0);
            end
         if (cfg_max == '0 && cfg_abort == 0) begin
            if (cfg_en == '0) cfg_abort = L + 1 + int'($urandom_range(0, 35));
            else succ_tab[40] = cfg_en;
         end
         run_one();
      end

      for (int w = 0; w < 20; w++) begin
         if (q.size() == 0) break;
         @(posedge clock);
      end
      chk("scoreboard_drain", 64'(q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
